spad_stream_ctrl: RTL and testbench

//  Sequencer for one scratchpad memory instance (1R/1W, registered read, 1-cycle latency).
//  On a start command it loads cfg_len words from a valid/ready input stream into the scratchpad.
//  The words go to consecutive addresses starting at cfg_base.
//  It then replays that region cfg_repeat times as a valid/ready output stream to the PE datapath.
//  It sits between the layer loader/feeder and the PE's weight/ifmap scratchpad.

---
 rtl/spad_stream_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_spad_stream_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spad_stream_ctrl.sv
// Scratchpad stream sequencer: loads a region from an input stream, then replays it
// a programmable number of times through a 2-entry output FIFO.
module spad_stream_ctrl #(
    parameter int unsigned DATA_BITWIDTH = 16,
    parameter int unsigned ADDR_BITWIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic [ADDR_BITWIDTH-1:0] cfg_base,
    input  logic [ADDR_BITWIDTH:0]   cfg_len,
    input  logic [7:0]               cfg_repeat,
    input  logic                     in_valid,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_BITWIDTH-1:0] out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     spad_read_request,
    output logic [ADDR_BITWIDTH-1:0] spad_read_addr,
    output logic                     spad_write_enable,
    output logic [ADDR_BITWIDTH-1:0] spad_write_addr,
    output logic [DATA_BITWIDTH-1:0] spad_write_data,
    input  logic [DATA_BITWIDTH-1:0] spad_read_data
);

    localparam int unsigned D = DATA_BITWIDTH;
    localparam int unsigned A = ADDR_BITWIDTH;
    localparam int unsigned L = ADDR_BITWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [A-1:0]        base_q, base_d;
    logic [L-1:0]        len_q, len_d;
    logic [7:0]          rep_q, rep_d;
    logic [L-1:0]        wr_cnt_q, wr_cnt_d;
    logic [L-1:0]        rd_idx_q, rd_idx_d;
    logic [7:0]          pass_q, pass_d;
    logic                rdone_q, rdone_d;
    logic                infl_q, infl_d;
    logic [1:0][D-1:0]   fifo_q, fifo_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;

    logic                pop;
    logic [2:0]          occ;
    logic                wr_hs;

    // Output FIFO: a word lands here the cycle after its read was issued.
    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        out_valid = (cnt_q != 2'd0);
        out_data  = fifo_q[rd_ptr_q];
        pop       = out_valid & out_ready;
        if (infl_q) begin
            fifo_d[wr_ptr_q] = spad_read_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = 2'(cnt_q + 2'(infl_q) - 2'(pop));
        occ   = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
    end

    // Sequencer next-state and strobes.
    always_comb begin
        state_d           = state_q;
        base_d            = base_q;
        len_d             = len_q;
        rep_d             = rep_q;
        wr_cnt_d          = wr_cnt_q;
        rd_idx_d          = rd_idx_q;
        pass_d            = pass_q;
        rdone_d           = rdone_q;
        in_ready          = 1'b0;
        wr_hs             = 1'b0;
        spad_write_enable = 1'b0;
        spad_write_addr   = '0;
        spad_write_data   = '0;
        spad_read_request = 1'b0;
        spad_read_addr    = '0;
        done              = 1'b0;
        busy              = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    base_d   = cfg_base;
                    len_d    = cfg_len;
                    rep_d    = cfg_repeat;
                    wr_cnt_d = '0;
                    rd_idx_d = '0;
                    pass_d   = '0;
                    rdone_d  = 1'b0;
                    state_d  = (cfg_len != '0) ? S_LOAD : S_FIN;
                end
            end
            S_LOAD: begin
                in_ready = (wr_cnt_q < len_q);
                wr_hs    = in_valid & in_ready;
                if (wr_hs) begin
                    spad_write_enable = 1'b1;
                    spad_write_addr   = A'(base_q + A'(wr_cnt_q));
                    spad_write_data   = in_data;
                    wr_cnt_d          = L'(wr_cnt_q + L'(1));
                    if (wr_cnt_q == L'(len_q - L'(1))) begin
                        state_d = (rep_q != 8'd0) ? S_READ : S_FIN;
                    end
                end
            end
            S_READ: begin
                // Issue only if the word can never overflow the 2-entry FIFO.
                if (!rdone_q && (occ < 3'd2)) begin
                    spad_read_request = 1'b1;
                    spad_read_addr    = A'(base_q + A'(rd_idx_q));
                    if (rd_idx_q == L'(len_q - L'(1))) begin
                        rd_idx_d = '0;
                        pass_d   = 8'(pass_q + 8'd1);
                        if (pass_q == 8'(rep_q - 8'd1)) begin
                            rdone_d = 1'b1;
                        end
                    end else begin
                        rd_idx_d = L'(rd_idx_q + L'(1));
                    end
                end
                if (rdone_q && (cnt_q == 2'd0) && !infl_q) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        infl_d = spad_read_request;
    end

    // State and datapath registers; reset also drops any in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            rep_q    <= '0;
            wr_cnt_q <= '0;
            rd_idx_q <= '0;
            pass_q   <= '0;
            rdone_q  <= 1'b0;
            infl_q   <= 1'b0;
            fifo_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            rep_q    <= rep_d;
            wr_cnt_q <= wr_cnt_d;
            rd_idx_q <= rd_idx_d;
            pass_q   <= pass_d;
            rdone_q  <= rdone_d;
            infl_q   <= infl_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_spad_stream_ctrl.sv
// Randomized bench for spad_stream_ctrl with a scratchpad model and a queue-based scoreboard.
module tb_spad_stream_ctrl;

    localparam int unsigned D     = 16;
    localparam int unsigned A     = 9;
    localparam int          DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [A-1:0]  cfg_base;
    logic [A:0]    cfg_len;
    logic [7:0]    cfg_repeat;
    logic          in_valid;
    logic [D-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [D-1:0]  out_data;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          spad_read_request;
    logic [A-1:0]  spad_read_addr;
    logic          spad_write_enable;
    logic [A-1:0]  spad_write_addr;
    logic [D-1:0]  spad_write_data;
    logic [D-1:0]  spad_read_data;

    logic [D-1:0]  mem [DEPTH];

    int checks = 0;
    int errors = 0;

    spad_stream_ctrl #(.DATA_BITWIDTH(D), .ADDR_BITWIDTH(A)) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_start         (cfg_start),
        .cfg_base          (cfg_base),
        .cfg_len           (cfg_len),
        .cfg_repeat        (cfg_repeat),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_ready         (out_ready),
        .busy              (busy),
        .done              (done),
        .spad_read_request (spad_read_request),
        .spad_read_addr    (spad_read_addr),
        .spad_write_enable (spad_write_enable),
        .spad_write_addr   (spad_write_addr),
        .spad_write_data   (spad_write_data),
        .spad_read_data    (spad_read_data)
    );

    always #5 clk = ~clk;

    // Registered-read scratchpad; the idle read bus carries junk that must never reach out_data.
    always @(posedge clk) begin
        if (spad_write_enable) mem[spad_write_addr] <= spad_write_data;
        spad_read_data <= spad_read_request ? mem[spad_read_addr] : D'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_rd_req"}, 32'(spad_read_request), 0);
        check({tag, "_wr_en"}, 32'(spad_write_enable), 0);
        check({tag, "_addrs"}, 32'({spad_read_addr, spad_write_addr}), 0);
        check({tag, "_wr_data"}, 32'(spad_write_data), 0);
    endtask

    // rmode: 0 always ready, 1 toggling, 2 random, 3 never ready
    task automatic run_cmd(input int base, input int len, input int rep, input int vprob,
                           input int rmode, input bit fixed, input bit abort_full);
        logic [D-1:0] words[$];
        logic [D-1:0] exp_out[$];
        int sent = 0, outn = 0, rdn = 0, strobes = 0, c = 0;
        int last_wr = -1, first_out = -1, last_out = -1, first_valid = -1, done_c = -1;
        bit aborted = 0;

        for (int i = 0; i < len; i++) words.push_back(fixed ? D'(32'hA1 + i) : D'($urandom));
        for (int p = 0; p < rep; p++)
            for (int i = 0; i < len; i++) exp_out.push_back(words[i]);

        @(negedge clk);
        cfg_start  = 1'b1;
        cfg_base   = A'(base);
        cfg_len    = (A + 1)'(len);
        cfg_repeat = 8'(rep);
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        #1;
        check("idle_before_start", 32'(busy), 0);

        while (done_c < 0 && c < 20000) begin
            @(negedge clk);
            c++;
            cfg_start  = ($urandom_range(0, 9) == 0);
            cfg_base   = A'($urandom);
            cfg_len    = (A + 1)'($urandom);
            cfg_repeat = 8'($urandom);
            in_valid   = (sent < len) && ($urandom_range(0, 99) < vprob);
            in_data    = in_valid ? words[sent] : D'($urandom);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = c[0];
                2:       out_ready = 1'($urandom);
                default: out_ready = 1'b0;
            endcase
            #1;
            if (spad_write_enable || spad_read_request) strobes++;
            if (spad_read_request) rdn++;
            if (spad_read_request && spad_write_enable) check("rw_same_cycle", 1, 0);
            if (spad_read_request && !busy) check("rd_while_idle", 1, 0);
            if (in_valid && in_ready) begin
                check("wr_en", 32'(spad_write_enable), 1);
                check("wr_addr", 32'(spad_write_addr), 32'((base + sent) % DEPTH));
                check("wr_data", 32'(spad_write_data), 32'(words[sent]));
                sent++;
                last_wr = c;
            end else if (spad_write_enable) begin
                check("wr_en_spurious", 32'(spad_write_enable), 0);
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid && out_ready) begin
                if (outn < exp_out.size()) check("out_data", 32'(out_data), 32'(exp_out[outn]));
                else check("out_extra", 32'(outn), 32'(exp_out.size()));
                if (first_out < 0) first_out = c;
                last_out = c;
                outn++;
            end
            if (done) begin
                done_c = c;
                check("busy_at_done", 32'(busy), 1);
            end
            if (abort_full && first_valid >= 0 && (c - first_valid) >= 3) begin
                aborted = 1;
                check("full_before_abort", 32'(out_valid), 1);
                break;
            end
        end

        if (aborted) begin
            @(negedge clk);
            reset = 1'b1; cfg_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            reset = 1'b0; out_ready = 1'b0;
            #1;
            check_quiet("after_abort");
            @(negedge clk);
            #1;
            check("no_done_after_abort", 32'(done), 0);
            return;
        end

        if (done_c < 0) check("timeout_done", 0, 1);
        check("wr_count", 32'(sent), 32'(len));
        check("out_count", 32'(outn), 32'(exp_out.size()));
        check("rd_count", 32'(rdn), 32'(len * rep));
        if (len == 0) begin
            check("len0_done_latency", 32'(done_c <= 2), 1);
            check("len0_no_strobes", 32'(strobes), 0);
        end
        if (rmode == 0 && len > 0 && rep > 0 && vprob >= 100) begin
            check("first_out_latency", 32'(first_out - last_wr), 3);
            check("gapless_stream", 32'(last_out - first_out), 32'(exp_out.size() - 1));
        end

        @(negedge clk);
        cfg_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("idle_after_done_busy", 32'(busy), 0);
        check("idle_after_done_pulse", 32'(done), 0);
    endtask

    initial begin
        reset      = 1'b1;
        cfg_start  = 1'b0;
        cfg_base   = '0;
        cfg_len    = '0;
        cfg_repeat = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b0;

        run_cmd(0, 4, 1, 100, 0, 1, 0);
        run_cmd(510, 4, 1, 100, 0, 0, 0);
        run_cmd(int'($urandom_range(0, 511)), 3, 3, 100, 1, 0, 0);
        run_cmd(37, 0, 5, 100, 0, 0, 0);
        run_cmd(200, 2, 0, 100, 0, 0, 0);
        run_cmd(int'($urandom_range(0, 511)), 10, 2, 50, 2, 0, 0);
        run_cmd(100, 6, 2, 100, 3, 0, 1);
        run_cmd(300, 5, 2, 100, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            run_cmd(int'($urandom_range(0, 511)), int'($urandom_range(1, 20)),
                    int'($urandom_range(0, 3)), int'($urandom_range(30, 100)),
                    int'($urandom_range(0, 2)), 0, 0);
        end
        run_cmd(7, 512, 1, 100, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
